// File: rtl/cla_addsub_pipe_if.sv
// Operand/result stream bundle for the pipelined CLA add/sub unit.
// The unit itself connects through the slave modport; the producer/consumer connects through master.
interface cla_addsub_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  cin;
  logic                  op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;
  logic                  ovf;
  logic                  zero;

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLK_WIDTH lookahead block per stage,
// carry registered between stages, valid/ready stream with full-pipeline stall.
module cla_addsub_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLK_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst,
  cla_addsub_pipe_if.slave bus
);
  localparam int unsigned NUM_BLK = DATA_WIDTH / BLK_WIDTH;
  localparam int unsigned NUM_GRP = BLK_WIDTH / 4;

  // 4-bit lookahead groups; groups ripple on the group carry inside a block.
  function automatic logic [BLK_WIDTH:0] blk_add(input logic [BLK_WIDTH-1:0] x,
                                                  input logic [BLK_WIDTH-1:0] y,
                                                  input logic                 c0);
    logic [BLK_WIDTH-1:0] g, p, s;
    logic [3:0]           gg, pp, cc;
    logic                 gc, grp_g, grp_p;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    gc = c0;
    for (int unsigned j = 0; j < NUM_GRP; j++) begin
      gg    = g[4*j +: 4];
      pp    = p[4*j +: 4];
      cc[0] = gc;
      cc[1] = gg[0] | (pp[0] & gc);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & gc);
      grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
      grp_p = &pp;
      s[4*j +: 4] = pp ^ cc;
      gc = grp_g | (grp_p & gc);
    end
    return {gc, s};
  endfunction

  logic [DATA_WIDTH-1:0] a_q [NUM_BLK];
  logic [DATA_WIDTH-1:0] a_d [NUM_BLK];
  logic [DATA_WIDTH-1:0] b_q [NUM_BLK];
  logic [DATA_WIDTH-1:0] b_d [NUM_BLK];
  logic [DATA_WIDTH-1:0] s_q [NUM_BLK];
  logic [DATA_WIDTH-1:0] s_d [NUM_BLK];
  logic                  c_q [NUM_BLK];
  logic                  c_d [NUM_BLK];
  logic                  v_q [NUM_BLK];
  logic                  v_d [NUM_BLK];
  logic                  ovf_q, ovf_d, zero_q, zero_d;
  logic                  stall;

  logic [DATA_WIDTH-1:0] ain, bin, sin;
  logic                  ci, vi;
  logic [BLK_WIDTH:0]    res;

  always_comb begin
    stall         = v_q[NUM_BLK-1] && !bus.out_ready;
    bus.in_ready  = !stall;
    bus.out_valid = v_q[NUM_BLK-1];
    bus.sum       = s_q[NUM_BLK-1];
    bus.cout      = c_q[NUM_BLK-1];
    bus.ovf       = ovf_q;
    bus.zero      = zero_q;
  end

  // Stage k operates on the values feeding its register; after each block the
  // working variables are reloaded from stage k's register to feed stage k+1.
  always_comb begin
    ain    = bus.a;
    bin    = bus.b ^ {DATA_WIDTH{bus.op}};
    ci     = bus.cin ^ bus.op;
    sin    = '0;
    vi     = bus.in_valid && !stall;
    res    = '0;
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    for (int unsigned k = 0; k < NUM_BLK; k++) begin
      res = blk_add(ain[k*BLK_WIDTH +: BLK_WIDTH], bin[k*BLK_WIDTH +: BLK_WIDTH], ci);
      sin[k*BLK_WIDTH +: BLK_WIDTH] = res[BLK_WIDTH-1:0];
      a_d[k] = ain;
      b_d[k] = bin;
      s_d[k] = sin;
      c_d[k] = res[BLK_WIDTH];
      v_d[k] = vi;
      ovf_d  = (ain[DATA_WIDTH-1] == bin[DATA_WIDTH-1]) && (sin[DATA_WIDTH-1] != ain[DATA_WIDTH-1]);
      zero_d = (sin == '0);
      ain    = a_q[k];
      bin    = b_q[k];
      sin    = s_q[k];
      ci     = c_q[k];
      vi     = v_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NUM_BLK; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe (32/8, latency 4) plus a single-stage 32/32 instance.
module tb_cla_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.DATA_WIDTH(32)) bus ();
  cla_addsub_pipe_if #(.DATA_WIDTH(32)) bus1 ();

  cla_addsub_pipe #(.DATA_WIDTH(32), .BLK_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  cla_addsub_pipe #(.DATA_WIDTH(32), .BLK_WIDTH(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic mo);
    logic [32:0] r;
    logic [31:0] be;
    logic        ov;
    be = mo ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {32'd0, (mo ? ~mc : mc)};
    ov = (ma[31] == be[31]) && (r[31] != ma[31]);
    return {(r[31:0] == 32'd0), ov, r[32], r[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) for its result; lat counts cycles to out_valid.
  task automatic send_beat(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                           input logic to, output logic [31:0] s, output logic co,
                           output logic ov, output logic z, output int lat);
    bus.a = ta; bus.b = tb_; bus.cin = tc; bus.op = to;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s = bus.sum; co = bus.cout; ov = bus.ovf; z = bus.zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.op = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 32'd0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    n_cmp++; if ({bus.cout, bus.ovf, bus.zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {bus.cout, bus.ovf, bus.zero}); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.a = 32'h1000 + 32'(i); bus.b = 32'd7; bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.sum !== 32'd0) begin n_err++; $display("FAIL reset_mid_flight got v=%b s=%h exp v=0 s=0", bus.out_valid, bus.sum); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_stale_beat cyc=%0d got v=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_carry_chain();
    logic [31:0] s; logic co, ov, z; int lat;
    send_beat(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, co, ov, z, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL chain_latency got=%0d exp=4", lat); end
    n_cmp++; if ({co, ov, z, s} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin n_err++; $display("FAIL chain_result got c=%b o=%b z=%b s=%h exp c=1 o=0 z=1 s=00000000", co, ov, z, s); end
    send_beat(32'h00FF_00FF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b0, 1'b0, 1'b0, 32'h00FF_0100}) begin n_err++; $display("FAIL blk_boundary got c=%b o=%b z=%b s=%h exp c=0 o=0 z=0 s=00ff0100", co, ov, z, s); end
    send_beat(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, s, co, ov, z, lat);
    n_cmp++; if ({co, s} !== {1'b0, 32'h0001_0001}) begin n_err++; $display("FAIL cin_boundary got c=%b s=%h exp c=0 s=00010001", co, s); end
  endtask

  task automatic test_subtract();
    logic [31:0] s; logic co, ov, z; int lat;
    send_beat(32'd5, 32'd7, 1'b0, 1'b1, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}) begin n_err++; $display("FAIL sub_borrow got c=%b o=%b z=%b s=%h exp c=0 o=0 z=0 s=fffffffe", co, ov, z, s); end
    send_beat(32'h8000_0000, 32'd1, 1'b0, 1'b1, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF}) begin n_err++; $display("FAIL sub_ovf got c=%b o=%b z=%b s=%h exp c=1 o=1 z=0 s=7fffffff", co, ov, z, s); end
    send_beat(32'd10, 32'd3, 1'b1, 1'b1, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b1, 1'b0, 1'b0, 32'd6}) begin n_err++; $display("FAIL sub_borrow_in got c=%b o=%b z=%b s=%h exp c=1 o=0 z=0 s=00000006", co, ov, z, s); end
    send_beat(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin n_err++; $display("FAIL sub_zero got c=%b o=%b z=%b s=%h exp c=1 o=0 z=1 s=00000000", co, ov, z, s); end
  endtask

  task automatic test_add_overflow();
    logic [31:0] s; logic co, ov, z; int lat;
    send_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, s, co, ov, z, lat);
    n_cmp++; if ({co, ov, z, s} !== {1'b0, 1'b1, 1'b0, 32'h8000_0000}) begin n_err++; $display("FAIL add_ovf got c=%b o=%b z=%b s=%h exp c=0 o=1 z=0 s=80000000", co, ov, z, s); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [16];
    logic [31:0] rb [16];
    logic        rc [16];
    logic        ro [16];
    logic [34:0] ex [16];
    logic [34:0] held;
    logic        was_stalled;
    int idx_in, got, cyc;
    for (int i = 0; i < 16; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rc[i] = 1'($urandom_range(1)); ro[i] = 1'($urandom_range(1));
      ex[i] = model(ra[i], rb[i], rc[i], ro[i]);
    end
    idx_in = 0; got = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while (got < 16 && cyc < 300) begin
      bus.out_ready = ((cyc % 3) == 0);
      bus.in_valid  = (idx_in < 16);
      if (idx_in < 16) begin
        bus.a = ra[idx_in]; bus.b = rb[idx_in]; bus.cin = rc[idx_in]; bus.op = ro[idx_in];
      end
      #1;
      n_cmp++; if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin n_err++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, !(bus.out_valid && !bus.out_ready)); end
      if (was_stalled) begin
        n_cmp++; if (bus.out_valid !== 1'b1 || {bus.zero, bus.ovf, bus.cout, bus.sum} !== held) begin n_err++; $display("FAIL stream_stable cyc=%0d got v=%b %h exp v=1 %h", cyc, bus.out_valid, {bus.zero, bus.ovf, bus.cout, bus.sum}, held); end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++; if ({bus.zero, bus.ovf, bus.cout, bus.sum} !== ex[got]) begin n_err++; $display("FAIL stream_result beat=%0d got=%h exp=%h", got, {bus.zero, bus.ovf, bus.cout, bus.sum}, ex[got]); end
        got++;
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held = {bus.zero, bus.ovf, bus.cout, bus.sum};
      if (bus.in_valid && bus.in_ready) idx_in++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_cmp++; if (got !== 16) begin n_err++; $display("FAIL stream_count got=%0d exp=16", got); end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_duplicate got v=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_bubbles();
    logic [31:0] exp_s [10];
    exp_s[4] = 32'd3; exp_s[6] = 32'd30; exp_s[7] = 32'h0000_0100;
    bus.out_ready = 1'b1; bus.op = 1'b0; bus.cin = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.in_valid = (cyc == 0 || cyc == 2 || cyc == 3);
      case (cyc)
        0: begin bus.a = 32'd1;  bus.b = 32'd2;  end
        2: begin bus.a = 32'd10; bus.b = 32'd20; end
        3: begin bus.a = 32'hFF; bus.b = 32'd1;  end
        default: begin bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111; end
      endcase
      n_cmp++; if (bus.out_valid !== (cyc == 4 || cyc == 6 || cyc == 7)) begin n_err++; $display("FAIL bubble_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, (cyc == 4 || cyc == 6 || cyc == 7)); end
      if (cyc == 4 || cyc == 6 || cyc == 7) begin
        n_cmp++; if (bus.sum !== exp_s[cyc]) begin n_err++; $display("FAIL bubble_sum cyc=%0d got=%h exp=%h", cyc, bus.sum, exp_s[cyc]); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_single_stage();
    bus1.a = 32'h1234_5678; bus1.b = 32'h0FED_CBA9; bus1.cin = 1'b0; bus1.op = 1'b0;
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.sum !== 32'h2222_2221) begin n_err++; $display("FAIL single_stage got v=%b s=%h exp v=1 s=22222221", bus1.out_valid, bus1.sum); end
    tick();
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL single_stage_bubble got v=%b exp=0", bus1.out_valid); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_subtract();
    test_add_overflow();
    tick();
    test_back_to_back();
    test_bubbles();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
